mem_arbiter: RTL and testbench

Arbitrates the single shared physical-memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the RV64 core. One transaction is outstanding at a time. Each request is latched, presented to memory, and its response is routed back to the requester that owns it. A hung memory response is bounded by a timeout. The block sits between the core datapath and the pmem access layer and replaces direct, unarbitrated memory calls.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arb_pick.sv | 52 +++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Holds the FSM state and owner encodings plus the default timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals for mem_arbiter.
// slave = the arbiter itself, master = core requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_write;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_write;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        input  lsu_req_valid, lsu_req_addr, lsu_req_write,
        input  lsu_req_wdata, lsu_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_write,
        output mem_req_wdata, mem_req_wmask
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        output lsu_req_valid, lsu_req_addr, lsu_req_write,
        output lsu_req_wdata, lsu_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_write,
        input  mem_req_wdata, mem_req_wmask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between IFU and LSU requests.
// MEM_ARB_RR_EN adds a last_grant register for round-robin ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   accept_i,
`endif
    input  logic   ifu_valid_i,
    input  logic   lsu_valid_i,
    output owner_t grant_o
);

`ifdef MEM_ARB_RR_EN
    owner_t last_q;
    owner_t last_d;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_o = OWN_LSU;
        last_d  = last_q;
        if (ifu_valid_i && lsu_valid_i) begin
            grant_o = (last_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (ifu_valid_i) begin
            grant_o = OWN_IFU;
        end
        if (accept_i) begin
            last_d = grant_o;
        end
    end

    // Remember who was granted; reset value lets IFU win the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= OWN_LSU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: LSU whenever it asks, otherwise IFU.
    always_comb begin
        grant_o = OWN_LSU;
        if (ifu_valid_i && !lsu_valid_i) begin
            grant_o = OWN_IFU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of the shared memory port (IFU vs LSU).
// Define MEM_ARB_RR_EN for round-robin; default is fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    owner_t            owner_q, owner_d;

    logic              ifu_rv_q, ifu_rv_d;
    logic [DATA_W-1:0] ifu_data_q, ifu_data_d;
    logic              ifu_err_q, ifu_err_d;
    logic              lsu_rv_q, lsu_rv_d;
    logic [DATA_W-1:0] lsu_data_q, lsu_data_d;
    logic              lsu_err_q, lsu_err_d;

    owner_t            grant;
    logic              accept;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk_i      (clk),
        .rst_i      (rst),
        .accept_i   (accept),
`endif
        .ifu_valid_i(bus.ifu_req_valid),
        .lsu_valid_i(bus.lsu_req_valid),
        .grant_o    (grant)
    );

    // Accept only in IDLE once the previous response pulse has gone out.
    assign accept = (state_q == IDLE) && !ifu_rv_q && !lsu_rv_q &&
                    (bus.ifu_req_valid || bus.lsu_req_valid);

    assign bus.ifu_req_ready  = accept && (grant == OWN_IFU);
    assign bus.lsu_req_ready  = accept && (grant == OWN_LSU);

    assign bus.mem_req_valid  = (state_q == REQ);
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_write  = write_q;
    assign bus.mem_req_wdata  = wdata_q;
    assign bus.mem_req_wmask  = write_q ? wmask_q : '0;

    assign bus.ifu_resp_valid = ifu_rv_q;
    assign bus.ifu_resp_data  = ifu_data_q;
    assign bus.ifu_resp_err   = ifu_err_q;
    assign bus.lsu_resp_valid = lsu_rv_q;
    assign bus.lsu_resp_data  = lsu_data_q;
    assign bus.lsu_resp_err   = lsu_err_q;

    // Next state, request latch, timeout counter and response routing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        owner_d    = owner_q;
        ifu_rv_d   = 1'b0;
        ifu_data_d = ifu_data_q;
        ifu_err_d  = ifu_err_q;
        lsu_rv_d   = 1'b0;
        lsu_data_d = lsu_data_q;
        lsu_err_d  = lsu_err_q;
        done       = 1'b0;
        done_err   = 1'b0;
        done_data  = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant;
                    if (grant == OWN_LSU) begin
                        addr_d  = bus.lsu_req_addr;
                        write_d = bus.lsu_req_write;
                        wdata_d = bus.lsu_req_wdata;
                        wmask_d = bus.lsu_req_wmask;
                    end else begin
                        addr_d  = bus.ifu_req_addr;
                        write_d = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.mem_resp_valid) begin
                    done      = 1'b1;
                    done_data = write_q ? '0 : bus.mem_resp_data;
                end else if (cnt_q == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            if (owner_q == OWN_LSU) begin
                lsu_rv_d   = 1'b1;
                lsu_data_d = done_data;
                lsu_err_d  = done_err;
            end else begin
                ifu_rv_d   = 1'b1;
                ifu_data_d = done_data;
                ifu_err_d  = done_err;
            end
        end
    end

    // State registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner_q    <= OWN_IFU;
            ifu_rv_q   <= 1'b0;
            ifu_data_q <= '0;
            ifu_err_q  <= 1'b0;
            lsu_rv_q   <= 1'b0;
            lsu_data_q <= '0;
            lsu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            owner_q    <= owner_d;
            ifu_rv_q   <= ifu_rv_d;
            ifu_data_q <= ifu_data_d;
            ifu_err_q  <= ifu_err_d;
            lsu_rv_q   <= lsu_rv_d;
            lsu_data_q <= lsu_data_d;
            lsu_err_q  <= lsu_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic
// compared each cycle against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: one transaction record with timestamps
    bit          m_busy, m_hs, m_wr, m_own_lsu, m_last_lsu = 1'b1;
    int          m_ths;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wmask;
    bit          p_ifu, p_lsu, p_err;
    logic [63:0] p_data;

    // samples taken at the negedge of the last tick
    logic        s_ifu_ready, s_lsu_ready, s_mem_valid, s_mem_write;
    logic [63:0] s_mem_addr, s_mem_wdata, s_ifu_data, s_lsu_data;
    logic [7:0]  s_mem_wmask;
    logic        s_ifu_rv, s_ifu_err, s_lsu_rv, s_lsu_err;
    bit          g_ifu, g_lsu;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit acc, acc_lsu, done, derr;
        logic [63:0] ddata;
        int k;
        @(negedge clk);
        s_ifu_ready = bus.ifu_req_ready;
        s_lsu_ready = bus.lsu_req_ready;
        s_mem_valid = bus.mem_req_valid;
        s_mem_addr  = bus.mem_req_addr;
        s_mem_write = bus.mem_req_write;
        s_mem_wdata = bus.mem_req_wdata;
        s_mem_wmask = bus.mem_req_wmask;
        s_ifu_rv    = bus.ifu_resp_valid;
        s_ifu_data  = bus.ifu_resp_data;
        s_ifu_err   = bus.ifu_resp_err;
        s_lsu_rv    = bus.lsu_resp_valid;
        s_lsu_data  = bus.lsu_resp_data;
        s_lsu_err   = bus.lsu_resp_err;
        g_ifu = bus.ifu_req_valid && s_ifu_ready;
        g_lsu = bus.lsu_req_valid && s_lsu_ready;
        if (!rst) begin
            chk("rst_ifu_ready", s_ifu_ready, 0);
            chk("rst_lsu_ready", s_lsu_ready, 0);
            chk("rst_mem_valid", s_mem_valid, 0);
            chk("rst_mem_addr", s_mem_addr, 0);
            chk("rst_mem_write", s_mem_write, 0);
            chk("rst_mem_wdata", s_mem_wdata, 0);
            chk("rst_mem_wmask", s_mem_wmask, 0);
            chk("rst_ifu_rv", s_ifu_rv, 0);
            chk("rst_ifu_data", s_ifu_data, 0);
            chk("rst_ifu_err", s_ifu_err, 0);
            chk("rst_lsu_rv", s_lsu_rv, 0);
            chk("rst_lsu_data", s_lsu_data, 0);
            chk("rst_lsu_err", s_lsu_err, 0);
            m_busy = 0; m_hs = 0; p_ifu = 0; p_lsu = 0;
            m_last_lsu = 1;
        end else begin
            acc = !m_busy && !p_ifu && !p_lsu &&
                  (bus.ifu_req_valid || bus.lsu_req_valid);
            acc_lsu = bus.lsu_req_valid;
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
                acc_lsu = !m_last_lsu;
`else
                acc_lsu = 1'b1;
`endif
            end
            chk("ifu_req_ready", s_ifu_ready, acc && !acc_lsu);
            chk("lsu_req_ready", s_lsu_ready, acc && acc_lsu);
            chk("mem_req_valid", s_mem_valid, m_busy && !m_hs);
            if (m_busy && !m_hs) begin
                chk("mem_req_addr", s_mem_addr, m_addr);
                chk("mem_req_write", s_mem_write, m_wr);
                if (m_wr) chk("mem_req_wdata", s_mem_wdata, m_wdata);
                chk("mem_req_wmask", s_mem_wmask, m_wr ? m_wmask : 8'h00);
            end
            chk("ifu_resp_valid", s_ifu_rv, p_ifu);
            chk("lsu_resp_valid", s_lsu_rv, p_lsu);
            if (p_ifu) begin
                chk("ifu_resp_data", s_ifu_data, p_data);
                chk("ifu_resp_err", s_ifu_err, p_err);
            end
            if (p_lsu) begin
                chk("lsu_resp_data", s_lsu_data, p_data);
                chk("lsu_resp_err", s_lsu_err, p_err);
            end
            done = 0; derr = 0; ddata = '0;
            if (m_busy && m_hs) begin
                k = cyc - m_ths;
                if (bus.mem_resp_valid) begin
                    done = 1;
                    ddata = m_wr ? 64'h0 : bus.mem_resp_data;
                end else if (k == TO) begin
                    done = 1; derr = 1;
                end
            end else if (m_busy && bus.mem_req_ready) begin
                m_hs = 1; m_ths = cyc;
            end
            p_ifu = done && !m_own_lsu;
            p_lsu = done && m_own_lsu;
            p_err = derr; p_data = ddata;
            if (done) m_busy = 0;
            if (acc) begin
                m_busy = 1; m_hs = 0; m_own_lsu = acc_lsu;
                m_last_lsu = acc_lsu;
                if (acc_lsu) begin
                    m_addr = bus.lsu_req_addr; m_wr = bus.lsu_req_write;
                    m_wdata = bus.lsu_req_wdata; m_wmask = bus.lsu_req_wmask;
                end else begin
                    m_addr = bus.ifu_req_addr; m_wr = 0;
                    m_wdata = '0; m_wmask = '0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic ifu_read(input logic [63:0] a, input logic [63:0] d);
        bus.ifu_req_valid = 1; bus.ifu_req_addr = a;
        tick();
        chk("pin_ifu_ready", s_ifu_ready, 1);
        chk("pin_lsu_ready_idle", s_lsu_ready, 0);
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        chk("pin_rd_valid", s_mem_valid, 1);
        chk("pin_rd_addr", s_mem_addr, a);
        chk("pin_rd_write", s_mem_write, 0);
        chk("pin_rd_wmask", s_mem_wmask, 0);
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_data = d;
        tick();
        chk("pin_rd_early", s_ifu_rv, 0);
        bus.mem_resp_valid = 0;
        tick();
        chk("pin_rd_rv", s_ifu_rv, 1);
        chk("pin_rd_data", s_ifu_data, d);
        chk("pin_rd_err", s_ifu_err, 0);
        chk("pin_rd_lsu_quiet", s_lsu_rv, 0);
        tick();
        chk("pin_rd_pulse_end", s_ifu_rv, 0);
    endtask

    task automatic run_grants(input int n, input bit rerise,
                              output bit [7:0] seq, output int got);
        got = 0; seq = '0;
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_2000;
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_3000;
        bus.lsu_req_write = 0; bus.lsu_req_wmask = 8'h00;
        bus.mem_req_ready = 1; bus.mem_resp_valid = 1;
        bus.mem_resp_data = 64'h0BAD_F00D_0000_0001;
        for (int t = 0; t < 60 && got < n; t++) begin
            tick();
            if (g_ifu || g_lsu) begin
                seq[got] = g_lsu;
                got++;
            end
            if (g_ifu) bus.ifu_req_valid = rerise;
            if (g_lsu) bus.lsu_req_valid = rerise;
        end
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        repeat (4) tick();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    endtask

    initial begin
        bit [7:0] seq;
        int got;
        bus.ifu_req_valid = 0; bus.ifu_req_addr = '0;
        bus.lsu_req_valid = 0; bus.lsu_req_addr = '0;
        bus.lsu_req_write = 0; bus.lsu_req_wdata = '0;
        bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
        bus.mem_resp_data = '0;
        do_reset();

        // single IFU read
        ifu_read(64'h8000_0000, 64'h1234_5678_8765_4321);

        // LSU store
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_1000;
        bus.lsu_req_write = 1; bus.lsu_req_wdata = 64'h1234_5678_8765_4321;
        bus.lsu_req_wmask = 8'hFF;
        tick();
        chk("pin_st_ready", s_lsu_ready, 1);
        bus.lsu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        chk("pin_st_addr", s_mem_addr, 64'h8000_1000);
        chk("pin_st_write", s_mem_write, 1);
        chk("pin_st_wdata", s_mem_wdata, 64'h1234_5678_8765_4321);
        chk("pin_st_wmask", s_mem_wmask, 8'hFF);
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
        bus.mem_resp_data = 64'hFFFF_EEEE_DDDD_CCCC;
        tick();
        bus.mem_resp_valid = 0;
        tick();
        chk("pin_st_rv", s_lsu_rv, 1);
        chk("pin_st_data", s_lsu_data, 0);
        chk("pin_st_err", s_lsu_err, 0);
        tick();

        // ties from reset
        do_reset();
        run_grants(2, 1'b0, seq, got);
        chk("pin_tie_count", got, 2);
`ifdef MEM_ARB_RR_EN
        chk("pin_tie_order", seq[1:0], 2'b10);
`else
        chk("pin_tie_order", seq[1:0], 2'b01);
`endif
        run_grants(4, 1'b1, seq, got);
        chk("pin_rep_count", got, 4);
`ifdef MEM_ARB_RR_EN
        chk("pin_rep_order", seq[3:0], 4'b1010);
`else
        chk("pin_rep_order", seq[3:0], 4'b1111);
`endif

        // memory stall, then reply on the last legal WAIT cycle
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_4000;
        bus.lsu_req_write = 0; bus.lsu_req_wmask = 8'h0F;
        tick();
        chk("pin_stall_acc", s_lsu_ready, 1);
        bus.lsu_req_valid = 0; bus.lsu_req_addr = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pin_stall_valid", s_mem_valid, 1);
            chk("pin_stall_addr", s_mem_addr, 64'h8000_4000);
            chk("pin_stall_wmask", s_mem_wmask, 0);
        end
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        repeat (3) tick();
        chk("pin_stall_norv", s_lsu_rv, 0);
        bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hCAFE_0000_BEEF_0001;
        tick();
        bus.mem_resp_valid = 0;
        tick();
        chk("pin_race_rv", s_lsu_rv, 1);
        chk("pin_race_err", s_lsu_err, 0);
        chk("pin_race_data", s_lsu_data, 64'hCAFE_0000_BEEF_0001);

        // timeout
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 64'h8000_5000;
        tick();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("pin_to_wait", s_ifu_rv, 0);
        end
        tick();
        chk("pin_to_rv", s_ifu_rv, 1);
        chk("pin_to_err", s_ifu_err, 1);
        chk("pin_to_data", s_ifu_data, 0);
        bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h5555;
        tick();
        bus.mem_resp_valid = 0;
        tick();
        chk("pin_stray_ifu", s_ifu_rv, 0);
        chk("pin_stray_lsu", s_lsu_rv, 0);

        // reset during WAIT
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h8000_6000;
        bus.lsu_req_write = 0;
        tick();
        bus.lsu_req_valid = 0; bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        tick();
        rst = 1'b0;
        #1;
        chk("pin_arst_addr", bus.mem_req_addr, 0);
        chk("pin_arst_valid", bus.mem_req_valid, 0);
        chk("pin_arst_lsu_rv", bus.lsu_resp_valid, 0);
        bus.mem_resp_valid = 1;
        repeat (2) tick();
        bus.mem_resp_valid = 0;
        rst = 1'b1;
        tick();
        chk("pin_arst_nopulse", s_lsu_rv, 0);
        ifu_read(64'h8000_7000, 64'hA5A5_5A5A_0F0F_F0F0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (g_ifu) bus.ifu_req_valid = 0;
            if (g_lsu) bus.lsu_req_valid = 0;
            if (!bus.ifu_req_valid && $urandom_range(0, 2) == 0) begin
                bus.ifu_req_valid = 1;
                bus.ifu_req_addr = {$urandom, $urandom};
            end
            if (!bus.lsu_req_valid && $urandom_range(0, 2) == 0) begin
                bus.lsu_req_valid = 1;
                bus.lsu_req_addr = {$urandom, $urandom};
                bus.lsu_req_write = 1'($urandom_range(0, 1));
                bus.lsu_req_wdata = {$urandom, $urandom};
                bus.lsu_req_wmask = 8'($urandom);
            end
            bus.mem_req_ready = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = ($urandom_range(0, 9) < 3);
            bus.mem_resp_data = {$urandom, $urandom};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
